// File: rtl/maple_pkg.sv
// maple_pkg: shared FSM states, m_tuser bit positions and bus pattern counts
// for the Maple receive path.
package maple_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, ARMED, RECV, TERM} state_t;
  localparam int TUSER_CRC   = 0;
  localparam int TUSER_LEN   = 1;
  localparam int TUSER_ABORT = 2;
  localparam int START_CNT   = 4;
  localparam int END_CNT     = 2;
endpackage

// File: rtl/maple_rx_fifo.sv
// maple_rx_fifo: output beat storage, entry = {tuser[2:0], tlast, tdata[7:0]};
// writes into a full store are dropped, reads from an empty store are ignored.
module maple_rx_fifo #(
  parameter int DEPTH = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       wr_en,
  input  logic [9:0] wr_data,
  output logic       full,
  input  logic       rd_en,
  output logic [9:0] rd_data,
  output logic       empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [9:0]    r_mem [2**AW];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr, w_rd;
  assign full    = r_cnt == (AW+1)'(DEPTH);
  assign empty   = r_cnt == '0;
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rp];
  always_ff @(posedge aclk)
    if (w_wr) r_mem[r_wp] <= wr_data;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_wr ? (r_wp == AW'(DEPTH - 1) ? '0 : r_wp + 1'b1) : r_wp;
      r_rp  <= w_rd ? (r_rp == AW'(DEPTH - 1) ? '0 : r_rp + 1'b1) : r_rp;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    end
endmodule

// File: rtl/maple_rx_frame_ctrl.sv
// maple_rx_frame_ctrl: Maple bus receive framing (start/end detect, length, CRC,
// watchdog) feeding an AXI-Stream byte output. MAPLE_RX_FIFO_EN selects a FIFO_DEPTH FIFO.
module maple_rx_frame_ctrl import maple_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       sdcka_data,
  input  logic       sdcka_posedge,
  input  logic       sdcka_negedge,
  input  logic       sdckb_data,
  input  logic       sdckb_posedge,
  input  logic       sdckb_negedge,
  output logic       dec_enable,
  input  logic [7:0] dec_tdata,
  input  logic       dec_tvalid,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic [2:0] m_tuser,
  output logic       busy,
  output logic       frame_done,
  output logic       err_overflow,
  input  logic       clr_err
);
`ifdef MAPLE_RX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1 + 0 * FIFO_DEPTH;
`endif
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  state_t        r_state;
  logic [2:0]    r_sync, w_sync_nxt;
  logic [1:0]    r_arun, w_arun_nxt;
  logic [9:0]    r_cnt, r_exp, w_n, w_wdata, w_rdata;
  logic [7:0]    r_crc;
  logic [WW-1:0] r_wd, w_wd_nxt;
  logic [2:0]    w_tuser;
  logic          r_len_err, r_abort, r_dec_en, r_ovf;
  logic          w_edge, w_tmo, w_end, w_first, w_last, w_over, w_term_beat;
  logic          w_dpush, w_tpush, w_push, w_full, w_empty;
  assign w_edge      = |{sdcka_posedge, sdcka_negedge, sdckb_posedge, sdckb_negedge};
  assign w_wd_nxt    = w_edge ? '0 : r_wd + 1'b1;
  assign w_tmo       = w_wd_nxt == WW'(TIMEOUT_CYCLES);
  assign w_arun_nxt  = sdckb_negedge ? '0 : r_arun + {1'b0, sdcka_negedge};
  assign w_end       = w_arun_nxt == 2'(END_CNT);
  assign w_sync_nxt  = r_sync + {2'b00, sdckb_negedge && !sdcka_data};
  assign w_first     = r_cnt == '0;
  assign w_n         = {dec_tdata, 2'b00} + 10'd5;
  assign w_last      = !w_first && (r_cnt + 10'd1 == r_exp);
  assign w_over      = !w_first && (r_cnt >= r_exp);
  // a terminal beat is owed for aborted or short frames, or a full frame followed by extra bytes
  assign w_term_beat = r_cnt != '0 && (r_abort || r_len_err || r_cnt < r_exp);
  assign w_dpush     = r_state == RECV && dec_tvalid && !w_over;
  assign w_tpush     = r_state == TERM && w_term_beat && !w_full;
  assign w_push      = w_dpush || w_tpush;
  always_comb begin
    w_tuser              = '0;
    w_tuser[TUSER_CRC]   = w_dpush && w_last && dec_tdata != r_crc;
    w_tuser[TUSER_LEN]   = !w_dpush && !r_abort;
    w_tuser[TUSER_ABORT] = !w_dpush && r_abort;
  end
  assign w_wdata = {w_tuser, !w_dpush || w_last, w_dpush ? dec_tdata : 8'h00};
  maple_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .aclk(aclk), .aresetn(aresetn),
    .wr_en(w_push), .wr_data(w_wdata), .full(w_full),
    .rd_en(m_tready), .rd_data(w_rdata), .empty(w_empty)
  );
  assign m_tvalid = !w_empty;
  assign {m_tuser, m_tlast, m_tdata} = m_tvalid ? w_rdata : '0;
  assign frame_done   = m_tvalid && m_tready && m_tlast;
  assign busy         = r_state != IDLE;
  assign dec_enable   = r_dec_en;
  assign err_overflow = r_ovf;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state   <= IDLE;
      r_sync    <= '0;
      r_arun    <= '0;
      r_cnt     <= '0;
      r_exp     <= '0;
      r_crc     <= '0;
      r_wd      <= '0;
      r_len_err <= 1'b0;
      r_abort   <= 1'b0;
      r_dec_en  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= (w_push && w_full) || (r_ovf && !clr_err);
      r_wd  <= r_state == RECV ? w_wd_nxt : '0;
      case (r_state)
        IDLE:
          if (sdcka_negedge && sdckb_data) begin
            r_state <= SYNC;
            r_sync  <= '0;
          end
        SYNC:
          if (sdcka_posedge) r_state <= IDLE;
          else begin
            r_sync <= w_sync_nxt;
            if (w_sync_nxt == 3'(START_CNT)) r_state <= ARMED;
          end
        ARMED:
          if (sdcka_posedge) begin
            r_state   <= RECV;
            r_dec_en  <= 1'b1;
            r_arun    <= '0;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_crc     <= '0;
            r_len_err <= 1'b0;
            r_abort   <= 1'b0;
          end
        RECV: begin
          r_arun <= w_arun_nxt;
          if (dec_tvalid) begin
            if (w_first) r_exp <= w_n;
            if (w_over) r_len_err <= 1'b1;
            else begin
              r_cnt <= r_cnt + 10'd1;
              r_crc <= w_last ? r_crc : r_crc ^ dec_tdata;
            end
          end
          if (w_end || w_tmo) begin
            r_state  <= TERM;
            r_dec_en <= 1'b0;
            r_abort  <= w_tmo && !w_end;
          end
        end
        TERM:
          if (!w_term_beat || !w_full) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_maple_rx_frame_ctrl.sv
// tb_maple_rx_frame_ctrl: directed frames with expected beats queued at stimulus
// time and checked by an independent output monitor.
module tb_maple_rx_frame_ctrl;
  logic       aclk = 1'b0, aresetn = 1'b0;
  logic       sdcka_data = 1'b1, sdcka_posedge = 1'b0, sdcka_negedge = 1'b0;
  logic       sdckb_data = 1'b1, sdckb_posedge = 1'b0, sdckb_negedge = 1'b0;
  logic       dec_enable, dec_tvalid = 1'b0;
  logic [7:0] dec_tdata = 8'h00, m_tdata;
  logic       m_tvalid, m_tready = 1'b0, m_tlast;
  logic [2:0] m_tuser;
  logic       busy, frame_done, err_overflow, clr_err = 1'b0;
  logic [9:0] q[$];
  int         n_cmp = 0, n_bad = 0;

  maple_rx_frame_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .sdcka_data(sdcka_data), .sdcka_posedge(sdcka_posedge), .sdcka_negedge(sdcka_negedge),
    .sdckb_data(sdckb_data), .sdckb_posedge(sdckb_posedge), .sdckb_negedge(sdckb_negedge),
    .dec_enable(dec_enable), .dec_tdata(dec_tdata), .dec_tvalid(dec_tvalid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .busy(busy), .frame_done(frame_done),
    .err_overflow(err_overflow), .clr_err(clr_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge aclk)
    if (aresetn && m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %0h expected none", {m_tuser, m_tlast, m_tdata});
      end else begin
        logic [9:0] e;
        e = q.pop_front();
        check("beat", {m_tuser, m_tlast, m_tdata}, e);
        check("frame_done", frame_done, e[8]);
      end
    end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_an();
    sdcka_negedge = 1'b1; tick(); sdcka_negedge = 1'b0; tick();
  endtask

  task automatic pulse_bn();
    sdckb_negedge = 1'b1; tick(); sdckb_negedge = 1'b0; tick();
  endtask

  task automatic start();
    sdckb_data = 1'b1;
    sdcka_data = 1'b0;
    pulse_an();
    repeat (4) pulse_bn();
    sdcka_data = 1'b1;
    sdcka_posedge = 1'b1; tick(); sdcka_posedge = 1'b0;
    check("dec_enable_on", dec_enable, 1);
  endtask

  task automatic send(input logic [7:0] b);
    dec_tdata = b; dec_tvalid = 1'b1; tick(); dec_tvalid = 1'b0; tick();
  endtask

  task automatic end_pat();
    pulse_an();
    pulse_an();
    check("dec_enable_off", dec_enable, 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    check(name, q.size(), 0);
    tick();
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic frame_ok();
    start();
    q.push_back(10'h000); send(8'h00);
    q.push_back(10'h011); send(8'h11);
    q.push_back(10'h022); send(8'h22);
    q.push_back(10'h033); send(8'h33);
    q.push_back({3'b000, 1'b1, 8'h00}); send(8'h00);
    end_pat();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_dec_enable", dec_enable, 0);
    check("rst_outs", {m_tdata, m_tlast, m_tuser, frame_done, err_overflow}, 0);
    aresetn = 1'b1;
    m_tready = 1'b1;
    tick();
    send(8'h77);
    repeat (3) tick();
    check("idle_dec_ignored", m_tvalid, 0);
    sdcka_data = 1'b0;
    pulse_an();
    check("sync_entered", busy, 1);
    pulse_bn();
    pulse_bn();
    sdcka_posedge = 1'b1; tick(); sdcka_posedge = 1'b0; tick();
    check("sync_abort_idle", busy, 0);
    frame_ok();
    drain("frame_ok");
    start();
    q.push_back(10'h000); send(8'h00);
    q.push_back(10'h011); send(8'h11);
    q.push_back(10'h022); send(8'h22);
    q.push_back(10'h033); send(8'h33);
    q.push_back({3'b001, 1'b1, 8'h01}); send(8'h01);
    end_pat();
    drain("frame_crc_err");
    start();
    q.push_back(10'h001); send(8'h01);
    q.push_back(10'h0aa); send(8'haa);
    q.push_back(10'h0bb); send(8'hbb);
    q.push_back({3'b010, 1'b1, 8'h00});
    end_pat();
    drain("frame_short");
    start();
    q.push_back(10'h000); send(8'h00);
    q.push_back(10'h011); send(8'h11);
    q.push_back(10'h022); send(8'h22);
    q.push_back(10'h033); send(8'h33);
    q.push_back({3'b000, 1'b1, 8'h00}); send(8'h00);
    send(8'h55);
    q.push_back({3'b010, 1'b1, 8'h00});
    end_pat();
    drain("frame_long");
    m_tready = 1'b0;
    start();
    q.push_back(10'h000); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    check("stall_held", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, 3'b000, 1'b0, 8'h00});
    check("ovf_set", err_overflow, 1);
    end_pat();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovf_cleared", err_overflow, 0);
    m_tready = 1'b1;
    drain("stall");
    start();
    q.push_back(10'h000); send(8'h00);
    q.push_back(10'h011); send(8'h11);
    q.push_back({3'b100, 1'b1, 8'h00});
    repeat (4000) tick();
    check("wd_still_recv", busy, 1);
    repeat (200) tick();
    check("wd_idle", busy, 0);
    drain("watchdog");
    m_tready = 1'b0;
    start();
    send(8'h00); send(8'h11);
    aresetn = 1'b0;
    #2;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dec_enable", dec_enable, 0);
    check("mid_rst_outs", {m_tdata, m_tlast, m_tuser, err_overflow}, 0);
    tick();
    aresetn = 1'b1;
    m_tready = 1'b1;
    tick();
    frame_ok();
    drain("after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
